// File: rtl/fb_fill_engine.sv
// Rectangle-fill writer for a 320x240 RGB444 framebuffer: clips a command to the
// screen and streams one registered pixel write per clock. Optional FB_FILL_CLEAR_EN adds clr_i.
module fb_fill_engine #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst,
`ifdef FB_FILL_CLEAR_EN
  input  logic               clr_i,
`endif
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [8:0]         x0_i,
  input  logic [7:0]         y0_i,
  input  logic [8:0]         x1_i,
  input  logic [7:0]         y1_i,
  input  logic [COLOR_W-1:0] color_i,
  output logic               we_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [COLOR_W-1:0] wdata_o,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL} state_t;

  localparam logic [8:0]        H_LIM  = 9'(H_RES);
  localparam logic [8:0]        X_MAX  = 9'(H_RES - 1);
  localparam logic [7:0]        V_LIM  = 8'(V_RES);
  localparam logic [7:0]        Y_MAX  = 8'(V_RES - 1);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  state_t               state_q, state_d;
  logic [8:0]           x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
  logic [7:0]           y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]   color_q, color_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]    row_base_q, row_base_d, addr_q, addr_d;
  logic                 last_q, last_d, we_q, we_d, done_q, done_d;

  // Pixel to emit this cycle and the (clamped) end corner it is scanned against
  logic [8:0]           px, ex;
  logic [7:0]           py, ey;
  logic [ADDR_W-1:0]    pbase;
  logic                 empty, emit;

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = 1'b0;
    px         = cur_x_q;
    py         = cur_y_q;
    pbase      = row_base_q;
    ex         = x1_q;
    ey         = y1_q;
    emit       = 1'b0;
    empty      = (x0_q > x1_q) || (y0_q > y1_q) || (x0_q >= H_LIM) || (y0_q >= V_LIM);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          x0_d    = x0_i;
          y0_d    = y0_i;
          x1_d    = x1_i;
          y1_d    = y1_i;
          color_d = color_i;
          state_d = S_SETUP;
        end
`ifdef FB_FILL_CLEAR_EN
        else if (clr_i) begin
          x0_d    = '0;
          y0_d    = '0;
          x1_d    = X_MAX;
          y1_d    = Y_MAX;
          color_d = '0;
          state_d = S_SETUP;
        end
`endif
      end
      S_SETUP: begin
        if (empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          // The first pixel is registered here so writes start the cycle FILL is entered
          ex      = (x1_q > X_MAX) ? X_MAX : x1_q;
          ey      = (y1_q > Y_MAX) ? Y_MAX : y1_q;
          x1_d    = ex;
          y1_d    = ey;
          px      = x0_q;
          py      = y0_q;
          pbase   = ADDR_W'(y0_q) * H_STEP;
          emit    = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          emit = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      we_d    = 1'b1;
      addr_d  = pbase + ADDR_W'(px);
      wdata_d = color_q;
      last_d  = (px == ex) && (py == ey);
      if (px == ex) begin
        cur_x_d    = x0_q;
        cur_y_d    = py + 8'd1;
        row_base_d = pbase + H_STEP;
      end else begin
        cur_x_d    = px + 9'd1;
        cur_y_d    = py;
        row_base_d = pbase;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      last_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      color_q    <= color_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign done_o      = done_q;

endmodule
